// File: rtl/anf_fl_tex_pkg.sv
// Shared types and constants for the texture fetch controller and the ETC2 decoder path.
package anf_fl_tex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MREQ  = 3'd1,
    ST_MWAIT = 3'd2,
    ST_DEC   = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_OFF_W = $clog2(BLOCK_BYTES);

  // Format codes understood by the ETC2 block decoder.
  localparam logic [4:0] FMT_ETC2_RGB8    = 5'd0;
  localparam logic [4:0] FMT_ETC2_RGBA8   = 5'd1;
  localparam logic [4:0] FMT_ETC2_RGB8A1  = 5'd2;
  localparam logic [4:0] FMT_EAC_R11      = 5'd3;
  localparam logic [4:0] FMT_EAC_RG11     = 5'd4;

  function automatic logic [31:0] pack_rgba(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b, input logic [7:0] a);
    return {r, g, b, a};
  endfunction

endpackage

// File: rtl/anf_fl_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module anf_fl_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/anf_fl_tex_fetch_ctrl.sv
// Texture fetch sequencer: one-entry block buffer in front of memory, registered operands
// for the external ETC2 decoder, and a registered RGBA response.
module anf_fl_tex_fetch_ctrl
  import anf_fl_tex_pkg::*;
#(
  parameter int BIDX_W = 28,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [BIDX_W-1:0]   req_bidx,
  input  logic [1:0]          req_u,
  input  logic [1:0]          req_v,
  input  logic [4:0]          req_format,
  input  logic [TAG_W-1:0]    req_tag,
  input  logic                inv,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [BIDX_W+3:0]   mem_addr,
  input  logic                mem_rsp_valid,
  input  logic [127:0]        mem_rsp_data,
  output logic [127:0]        dec_data,
  output logic [4:0]          dec_format,
  output logic [1:0]          dec_u,
  output logic [1:0]          dec_v,
  input  logic [7:0]          dec_r,
  input  logic [7:0]          dec_g,
  input  logic [7:0]          dec_b,
  input  logic [7:0]          dec_a,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rgba,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt,
  output logic [2:0]          dbg_state
);

  // Handshakes: a transfer happens on a clk edge where valid && ready are both high;
  // valid never depends on ready, and payloads hold steady while valid is high and ready is low.

  state_e              state_q, state_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [1:0]          u_q, u_d, v_q, v_d;
  logic [4:0]          fmt_q, fmt_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                buf_valid_q, buf_valid_d;
  logic [BIDX_W-1:0]   buf_bidx_q, buf_bidx_d;
  logic [127:0]        buf_data_q, buf_data_d;
  logic                inv_seen_q, inv_seen_d;
  logic [31:0]         rgba_q, rgba_d;
  logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
  logic                accept, is_hit, hit_inc, miss_inc;

  // req_ready is held low while reset is asserted, even though state already reads IDLE.
  assign req_ready = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign is_hit    = buf_valid_q && (buf_bidx_q == req_bidx);

  always_comb begin
    state_d     = state_q;
    bidx_d      = bidx_q;
    u_d         = u_q;
    v_d         = v_q;
    fmt_d       = fmt_q;
    tag_d       = tag_q;
    buf_valid_d = buf_valid_q && !inv;
    buf_bidx_d  = buf_bidx_q;
    buf_data_d  = buf_data_q;
    inv_seen_d  = inv_seen_q;
    rgba_d      = rgba_q;
    rsp_tag_d   = rsp_tag_q;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;

    case (state_q)
      ST_MREQ: begin
        inv_seen_d = inv_seen_q || inv;
        if (mem_req_ready) state_d = ST_MWAIT;
      end
      ST_MWAIT: begin
        inv_seen_d = inv_seen_q || inv;
        if (mem_rsp_valid) begin
          // The data is always used for the pending request; only validity depends on inv.
          buf_data_d  = mem_rsp_data;
          buf_bidx_d  = bidx_q;
          buf_valid_d = !(inv_seen_q || inv);
          state_d     = ST_DEC;
        end
      end
      ST_DEC: begin
        rgba_d    = pack_rgba(dec_r, dec_g, dec_b, dec_a);
        rsp_tag_d = tag_q;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      bidx_d     = req_bidx;
      u_d        = req_u;
      v_d        = req_v;
      fmt_d      = req_format;
      tag_d      = req_tag;
      inv_seen_d = inv;
      if (is_hit) begin
        state_d = ST_DEC;
        hit_inc = 1'b1;
      end else begin
        state_d  = ST_MREQ;
        miss_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bidx_q      <= '0;
      u_q         <= '0;
      v_q         <= '0;
      fmt_q       <= '0;
      tag_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_bidx_q  <= '0;
      buf_data_q  <= '0;
      inv_seen_q  <= 1'b0;
      rgba_q      <= '0;
      rsp_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      bidx_q      <= bidx_d;
      u_q         <= u_d;
      v_q         <= v_d;
      fmt_q       <= fmt_d;
      tag_q       <= tag_d;
      buf_valid_q <= buf_valid_d;
      buf_bidx_q  <= buf_bidx_d;
      buf_data_q  <= buf_data_d;
      inv_seen_q  <= inv_seen_d;
      rgba_q      <= rgba_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  anf_fl_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (hit_inc),
    .cnt   (hit_cnt)
  );

  anf_fl_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (miss_inc),
    .cnt   (miss_cnt)
  );

  assign mem_req_valid = (state_q == ST_MREQ);
  assign mem_addr      = {bidx_q, {BLOCK_OFF_W{1'b0}}};
  assign dec_data      = buf_data_q;
  assign dec_format    = fmt_q;
  assign dec_u         = u_q;
  assign dec_v         = v_q;
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_rgba      = rgba_q;
  assign rsp_tag       = rsp_tag_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_anf_fl_tex_fetch_ctrl.sv
// Bench for anf_fl_tex_fetch_ctrl: directed steps followed by random traffic against a
// transaction-level model of the block buffer, counters and stand-in decoder.
module tb_anf_fl_tex_fetch_ctrl;

  localparam int BW = 28;
  localparam int TW = 4;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [BW-1:0]   req_bidx = '0;
  logic [1:0]      req_u = '0, req_v = '0;
  logic [4:0]      req_format = '0;
  logic [TW-1:0]   req_tag = '0;
  logic            inv = 1'b0;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic [BW+3:0]   mem_addr;
  logic            mem_rsp_valid = 1'b0;
  logic [127:0]    mem_rsp_data = '0;
  logic [127:0]    dec_data;
  logic [4:0]      dec_format;
  logic [1:0]      dec_u, dec_v;
  logic [7:0]      dec_r, dec_g, dec_b, dec_a;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [31:0]     rsp_rgba;
  logic [TW-1:0]   rsp_tag;
  logic [CW-1:0]   hit_cnt, miss_cnt;
  logic [2:0]      dbg_state;

  int vectors = 0;
  int errors = 0;
  int mon_reads = 0;
  int m_reads = 0;
  int m_hit = 0;
  int m_miss = 0;
  bit            m_valid = 1'b0;
  logic [BW-1:0] m_bidx = '0;
  logic [127:0]  m_data = '0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (rst_n && mem_req_valid && mem_req_ready) mon_reads <= mon_reads + 1;
  end

  // Stand-in for the ETC2 decoder: any fixed mixing of block bytes by texel and format.
  function automatic logic [31:0] dec_model(input logic [127:0] d, input logic [4:0] f,
                                            input logic [1:0] u, input logic [1:0] v);
    int idx;
    logic [7:0] r, g, b, a;
    idx = int'({v, u});
    r = d[idx*8 +: 8];
    g = d[(15-idx)*8 +: 8] ^ {3'b000, f};
    b = d[((idx+5)%16)*8 +: 8];
    a = {u, v, f[3:0]} ^ d[127:120];
    return {r, g, b, a};
  endfunction

  assign {dec_r, dec_g, dec_b, dec_a} = dec_model(dec_data, dec_format, dec_u, dec_v);

  anf_fl_tex_fetch_ctrl #(.BIDX_W(BW), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_bidx      (req_bidx),
    .req_u         (req_u),
    .req_v         (req_v),
    .req_format    (req_format),
    .req_tag       (req_tag),
    .inv           (inv),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .dec_data      (dec_data),
    .dec_format    (dec_format),
    .dec_u         (dec_u),
    .dec_v         (dec_v),
    .dec_r         (dec_r),
    .dec_g         (dec_g),
    .dec_b         (dec_b),
    .dec_a         (dec_a),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rgba      (rsp_rgba),
    .rsp_tag       (rsp_tag),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
    .dbg_state     (dbg_state)
  );

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  // scoreboard compare
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: issue one request (from IDLE or RESP) and follow it to its response, leaving the
  // controller in RESP with rsp_ready low after 'stall' extra held cycles.
  task automatic run_req(input logic [BW-1:0] b, input logic [1:0] u, input logic [1:0] v,
                         input logic [4:0] f, input logic [TW-1:0] t,
                         input int gnt_dly, input int rsp_dly,
                         input bit inv_acc, input bit inv_wait, input int stall);
    bit exp_hit;
    bit inv_any;
    logic [127:0] d;
    logic [31:0] exp_rgba;
    exp_hit = m_valid && (m_bidx == b);
    req_valid = 1'b1; req_bidx = b; req_u = u; req_v = v; req_format = f; req_tag = t;
    rsp_ready = 1'b1; inv = inv_acc;
    #1 chk("accept_req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b0; inv = 1'b0;
    req_bidx = rand128(); req_u = 2'($urandom); req_v = 2'($urandom);
    if (inv_acc) m_valid = 1'b0;
    if (exp_hit) begin
      m_hit = sat_inc(m_hit);
      chk("hit_no_mem_req", mem_req_valid, 0);
    end else begin
      m_miss = sat_inc(m_miss);
      inv_any = inv_acc;
      for (int i = 0; i < gnt_dly; i++) begin
        chk("mreq_valid_held", mem_req_valid, 1);
        chk("mreq_addr_held", mem_addr, {b, 4'h0});
        @(negedge clk);
      end
      chk("mreq_valid", mem_req_valid, 1);
      chk("mreq_addr", mem_addr, {b, 4'h0});
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      m_reads++;
      for (int i = 0; i < rsp_dly; i++) begin
        chk("mwait_no_mem_req", mem_req_valid, 0);
        chk("mwait_no_rsp", rsp_valid, 0);
        if (inv_wait && i == 0) begin
          inv = 1'b1; inv_any = 1'b1;
        end
        @(negedge clk);
        inv = 1'b0;
      end
      if (inv_wait && rsp_dly == 0) begin
        inv = 1'b1; inv_any = 1'b1;
      end
      d = rand128();
      mem_rsp_valid = 1'b1; mem_rsp_data = d;
      @(negedge clk);
      mem_rsp_valid = 1'b0; inv = 1'b0; mem_rsp_data = rand128();
      m_data = d; m_bidx = b; m_valid = !inv_any;
    end
    chk("dec_no_rsp_yet", rsp_valid, 0);
    chk("dec_data", dec_data, m_data);
    @(negedge clk);
    exp_rgba = dec_model(m_data, f, u, v);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rgba", rsp_rgba, exp_rgba);
    chk("rsp_tag", rsp_tag, t);
    chk("hit_cnt", hit_cnt, m_hit);
    chk("miss_cnt", miss_cnt, m_miss);
    chk("mem_reads", mon_reads, m_reads);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_rgba", rsp_rgba, exp_rgba);
      chk("stall_rsp_tag", rsp_tag, t);
      chk("stall_req_ready", req_ready, 0);
    end
  endtask

  // Driver: consume the pending response without a new request.
  task automatic drain(input bit inv_r, input bit stray);
    rsp_ready = 1'b1; inv = inv_r;
    if (stray) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = rand128();
    end
    #1 chk("resp_req_ready", req_ready, 1);
    @(negedge clk);
    rsp_ready = 1'b0; inv = 1'b0; mem_rsp_valid = 1'b0;
    if (inv_r) m_valid = 1'b0;
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_mem_req", mem_req_valid, 0);
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rgba", rsp_rgba, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_dec_data", dec_data, 0);
    rst_n = 1'b1;
    #1 chk("post_rst_req_ready", req_ready, 1);
    // stray memory response in IDLE is ignored
    mem_rsp_valid = 1'b1; mem_rsp_data = rand128();
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("stray_idle_rsp_valid", rsp_valid, 0);
    chk("stray_idle_dec_data", dec_data, 0);

    // first miss, data after 3 cycles, then a hit held off for 5 cycles, then a queued hit
    run_req(28'h10, 2'd1, 2'd2, 5'd1, 4'd3, 0, 3, 1'b0, 1'b0, 0);
    drain(1'b0, 1'b0);
    run_req(28'h10, 2'd3, 2'd3, 5'd0, 4'd5, 0, 0, 1'b0, 1'b0, 5);
    run_req(28'h10, 2'd0, 2'd1, 5'd2, 4'd6, 0, 0, 1'b0, 1'b0, 0);
    run_req(28'h10, 2'd2, 2'd0, 5'd4, 4'd7, 0, 0, 1'b0, 1'b0, 0);
    drain(1'b0, 1'b0);

    // grant withheld for 4 cycles
    run_req(28'h22, 2'd1, 2'd1, 5'd3, 4'd9, 4, 2, 1'b0, 1'b0, 0);
    drain(1'b0, 1'b0);

    // inv during MWAIT: response still uses the fill, repeat misses
    run_req(28'h30, 2'd2, 2'd3, 5'd1, 4'd1, 0, 3, 1'b0, 1'b1, 0);
    drain(1'b0, 1'b0);
    run_req(28'h30, 2'd0, 2'd0, 5'd1, 4'd2, 1, 1, 1'b0, 1'b0, 0);
    // inv alongside a hit accept: still a hit, entry gone afterwards
    run_req(28'h30, 2'd1, 2'd3, 5'd0, 4'd4, 0, 0, 1'b1, 1'b0, 0);
    run_req(28'h30, 2'd3, 2'd1, 5'd2, 4'd8, 0, 1, 1'b0, 1'b0, 0);
    drain(1'b0, 1'b1);

    // reset during MWAIT, late response ignored
    req_valid = 1'b1; req_bidx = 28'h44; req_u = 2'd1; req_v = 2'd1; req_format = 5'd0; req_tag = 4'd2;
    @(negedge clk);
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("mwait_rst_req_ready", req_ready, 0);
    chk("mwait_rst_rsp_valid", rsp_valid, 0);
    chk("mwait_rst_mem_req", mem_req_valid, 0);
    chk("mwait_rst_hit_cnt", hit_cnt, 0);
    chk("mwait_rst_miss_cnt", miss_cnt, 0);
    rst_n = 1'b1;
    m_valid = 1'b0; m_hit = 0; m_miss = 0; m_reads = m_reads + 1; m_data = '0;
    #1 chk("mwait_rst_release_ready", req_ready, 1);
    mem_rsp_valid = 1'b1; mem_rsp_data = rand128();
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("late_rsp_no_valid", rsp_valid, 0);
    chk("late_rsp_dec_data", dec_data, 0);
    @(negedge clk);
    chk("late_rsp_no_valid2", rsp_valid, 0);
    run_req(28'h44, 2'd1, 2'd1, 5'd0, 4'd2, 0, 2, 1'b0, 1'b0, 0);
    drain(1'b0, 1'b0);

    // random traffic over a few blocks; counters reach saturation
    for (int n = 0; n < 60; n++) begin
      run_req(BW'($urandom_range(0, 3)), 2'($urandom), 2'($urandom), 5'($urandom_range(0, 4)),
              TW'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) drain(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end
    drain(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
